// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//   Shares the single GPR write port between the in-order pipeline writeback
//   and the multi-cycle mul/div unit (MDU). MDU results land in a one-entry
//   hold buffer and are written whenever the pipeline is idle. They are forced
//   through once they have lost arbitration MAX_WAIT times in a row. A
//   scoreboard tracks destinations with MDU results still outstanding so
//   decode can stall on RAW/WAW hazards.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   pipe_valid/waddr/wdata       pipeline writeback request
//   pipe_ready                   pipeline request accepted this cycle
//   mdu_valid/waddr/wdata        MDU result
//   mdu_ready                    MDU result accepted into the hold buffer
//   issue_valid, issue_rd        MDU op issued; marks issue_rd pending
//   chk_rs1/rs2/rd               operands of the instruction in decode
//   hazard                       any checked register is pending
//   rf_wen/waddr/wdata           register file write port (registered)
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int XLEN           = 64,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MAX_WAIT       = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pipe_valid,
    input  logic [REG_ADDR_WIDTH-1:0] pipe_waddr,
    input  logic [XLEN-1:0]           pipe_wdata,
    output logic                      pipe_ready,
    input  logic                      mdu_valid,
    input  logic [REG_ADDR_WIDTH-1:0] mdu_waddr,
    input  logic [XLEN-1:0]           mdu_wdata,
    output logic                      mdu_ready,
    input  logic                      issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    input  logic [REG_ADDR_WIDTH-1:0] chk_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] chk_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] chk_rd,
    output logic                      hazard,
    output logic                      rf_wen,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
    output logic [XLEN-1:0]           rf_wdata
);

    localparam int NREG  = 1 << REG_ADDR_WIDTH;
    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    logic                      hold_v;
    logic [REG_ADDR_WIDTH-1:0] hold_addr;
    logic [XLEN-1:0]           hold_data;
    logic [CNT_W-1:0]          wait_cnt;
    logic [NREG-1:0]           pending;
    logic [NREG-1:0]           pending_nxt;

    logic force_hold;
    logic hold_grant;
    logic pipe_grant;
    logic mdu_xfer;

    // Arbitration: the pipeline normally wins; a starved hold entry is forced.
    assign force_hold = hold_v && (wait_cnt == WAIT_MAX);
    assign hold_grant = hold_v && (!pipe_valid || force_hold);
    assign pipe_grant = pipe_valid && !force_hold;
    assign pipe_ready = !force_hold;
    // The hold entry can be refilled in the same cycle it drains.
    assign mdu_ready  = !hold_v || hold_grant;
    assign mdu_xfer   = mdu_valid && mdu_ready;

    assign hazard = pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd];

    // Clear is applied before set so a re-issue to the draining register
    // keeps it pending. x0 never becomes pending.
    always_comb begin
        pending_nxt = pending;
        if (hold_grant) pending_nxt[hold_addr] = 1'b0;
        if (issue_valid) pending_nxt[issue_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    // Hold buffer, starvation counter and scoreboard
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_v    <= 1'b0;
            hold_addr <= '0;
            hold_data <= '0;
            wait_cnt  <= '0;
            pending   <= '0;
        end else begin
            pending <= pending_nxt;
            if (mdu_xfer) begin
                hold_v    <= 1'b1;
                hold_addr <= mdu_waddr;
                hold_data <= mdu_wdata;
            end else if (hold_grant) begin
                hold_v <= 1'b0;
            end
            if (hold_grant) begin
                wait_cnt <= '0;
            end else if (hold_v && pipe_grant && (wait_cnt != WAIT_MAX)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // Write port register: one cycle after the grant. An x0 winner is
    // consumed with the enable held low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (hold_grant) begin
            rf_wen   <= (hold_addr != '0);
            rf_waddr <= hold_addr;
            rf_wdata <= hold_data;
        end else if (pipe_grant) begin
            rf_wen   <= (pipe_waddr != '0);
            rf_waddr <= pipe_waddr;
            rf_wdata <= pipe_wdata;
        end else begin
            rf_wen <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_valid;
    logic [4:0]  pipe_waddr;
    logic [63:0] pipe_wdata;
    logic        pipe_ready;
    logic        mdu_valid;
    logic [4:0]  mdu_waddr;
    logic [63:0] mdu_wdata;
    logic        mdu_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  chk_rs1, chk_rs2, chk_rd;
    logic        hazard;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.XLEN(64), .REG_ADDR_WIDTH(5), .MAX_WAIT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_valid(pipe_valid), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .pipe_ready(pipe_ready),
        .mdu_valid(mdu_valid), .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata),
        .mdu_ready(mdu_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
        .hazard(hazard),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the write port as a set of architectural facts.
    bit          m_hold_v;
    logic [4:0]  m_hold_a;
    logic [63:0] m_hold_d;
    int          m_losses;
    bit          m_pend [32];
    bit          m_wen;
    logic [4:0]  m_waddr;
    logic [63:0] m_wdata;
    bit          last_pipe_ready, last_mdu_ready;

    task automatic model_reset();
        m_hold_v = 0; m_hold_a = '0; m_hold_d = '0; m_losses = 0;
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
        m_wen = 0; m_waddr = '0; m_wdata = '0;
        last_pipe_ready = 1; last_mdu_ready = 1;
    endtask

    // Called just after a falling edge with inputs already applied: checks
    // this cycle's outputs, then advances the model across the rising edge.
    task automatic cycle();
        bit starved, hold_wins, pipe_wins, e_pipe_rdy, e_mdu_rdy, e_haz;
        #1;
        starved    = m_hold_v && (m_losses >= 3);
        hold_wins  = m_hold_v && (!pipe_valid || starved);
        pipe_wins  = pipe_valid && !starved;
        e_pipe_rdy = !starved;
        e_mdu_rdy  = !m_hold_v || hold_wins;
        e_haz      = m_pend[chk_rs1] || m_pend[chk_rs2] || m_pend[chk_rd];
        check_eq("pipe_ready", pipe_ready, e_pipe_rdy);
        check_eq("mdu_ready",  mdu_ready,  e_mdu_rdy);
        check_eq("hazard",     hazard,     e_haz);
        check_eq("rf_wen",     rf_wen,     m_wen);
        check_eq("rf_waddr",   rf_waddr,   m_waddr);
        check_eq("rf_wdata",   rf_wdata,   m_wdata);
        if (hold_wins) begin
            m_wen = (m_hold_a != 0); m_waddr = m_hold_a; m_wdata = m_hold_d;
            m_losses = 0;
            m_pend[m_hold_a] = 0;
        end else begin
            if (pipe_wins) begin
                m_wen = (pipe_waddr != 0); m_waddr = pipe_waddr; m_wdata = pipe_wdata;
            end else begin
                m_wen = 0;
            end
            if (m_hold_v && pipe_wins && m_losses < 3) m_losses++;
        end
        if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1;
        if (mdu_valid && e_mdu_rdy) begin
            m_hold_v = 1; m_hold_a = mdu_waddr; m_hold_d = mdu_wdata;
        end else if (hold_wins) begin
            m_hold_v = 0;
        end
        last_pipe_ready = e_pipe_rdy;
        last_mdu_ready  = e_mdu_rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        pipe_valid = 0; pipe_waddr = '0; pipe_wdata = '0;
        mdu_valid = 0; mdu_waddr = '0; mdu_wdata = '0;
        issue_valid = 0; issue_rd = '0;
        chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst_n = 0;
        pipe_valid = 1; pipe_waddr = 5'd3; pipe_wdata = 64'h55;

        // Reset held with a pending pipeline request
        repeat (2) @(negedge clk);
        for (int r = 0; r < 32; r += 9) begin
            chk_rs1 = 5'(r); chk_rs2 = 5'(r + 1); chk_rd = 5'(r + 2);
            #1;
            check_eq("rst_rf_wen", rf_wen, 0);
            check_eq("rst_hazard", hazard, 0);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        #1;
        check_eq("rel_pipe_ready", pipe_ready, 1);
        check_eq("rel_mdu_ready", mdu_ready, 1);
        @(negedge clk);

        // Pipeline write to x5, then an x0 write that is swallowed
        pipe_valid = 1; pipe_waddr = 5'd5; pipe_wdata = 64'h1234;
        cycle();
        pipe_waddr = 5'd0; pipe_wdata = 64'hffff;
        #1;
        check_eq("x5_wen", rf_wen, 1);
        check_eq("x5_waddr", rf_waddr, 5);
        check_eq("x5_wdata", rf_wdata, 64'h1234);
        cycle();
        pipe_valid = 0;
        #1;
        check_eq("x0_wen", rf_wen, 0);
        cycle();

        // MDU result to x7 with a RAW check in decode
        issue_valid = 1; issue_rd = 5'd7;
        cycle();
        issue_valid = 0; chk_rs1 = 5'd7;
        #1;
        check_eq("x7_hazard_set", hazard, 1);
        mdu_valid = 1; mdu_waddr = 5'd7; mdu_wdata = 64'hdead;
        cycle();
        mdu_valid = 0;
        cycle();
        #1;
        check_eq("x7_wen", rf_wen, 1);
        check_eq("x7_wdata", rf_wdata, 64'hdead);
        check_eq("x7_hazard_clr", hazard, 0);
        cycle();

        // Contention: pipe streams while the hold entry waits
        issue_valid = 1; issue_rd = 5'd3;
        mdu_valid = 1; mdu_waddr = 5'd3; mdu_wdata = 64'h3333;
        for (int k = 0; k < 7; k++) begin
            pipe_valid = 1; pipe_waddr = 5'(20 + k); pipe_wdata = 64'(k + 100);
            if (k == 1) begin issue_valid = 0; mdu_valid = 0; end
            #1;
            if (k == 4) check_eq("force_pipe_ready", pipe_ready, 0);
            if (k == 5) check_eq("force_rf_waddr", rf_waddr, 3);
            cycle();
        end
        pipe_valid = 0;
        cycle();

        // Back-to-back MDU results with the pipeline idle
        for (int k = 0; k < 4; k++) begin
            mdu_valid = 1; mdu_waddr = 5'(10 + k); mdu_wdata = 64'(k + 64'hA0);
            cycle();
        end
        mdu_valid = 0;
        repeat (2) cycle();

        // Re-issue to x9 in the cycle its previous result drains
        issue_valid = 1; issue_rd = 5'd9;
        mdu_valid = 1; mdu_waddr = 5'd9; mdu_wdata = 64'h99;
        cycle();
        mdu_valid = 0;
        cycle();
        chk_rs1 = 5'd9;
        cycle();
        issue_valid = 0;
        #1;
        check_eq("x9_still_pending", hazard, 1);
        cycle();

        // Asynchronous reset in the middle of a held result
        issue_valid = 1; issue_rd = 5'd12; chk_rd = 5'd12;
        pipe_valid = 1; pipe_waddr = 5'd1; pipe_wdata = 64'h1;
        mdu_valid = 1; mdu_waddr = 5'd12; mdu_wdata = 64'hc;
        cycle();
        issue_valid = 0; mdu_valid = 0;
        #2;
        rst_n = 0;
        #1;
        check_eq("arst_rf_wen", rf_wen, 0);
        check_eq("arst_rf_wdata", rf_wdata, 0);
        check_eq("arst_mdu_ready", mdu_ready, 1);
        check_eq("arst_hazard", hazard, 0);
        model_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        cycle();

        // Randomised traffic honouring the valid/ready hold rule
        for (int n = 0; n < 3000; n++) begin
            if (!(pipe_valid && !last_pipe_ready)) begin
                pipe_valid = ($urandom_range(99) < 60);
                pipe_waddr = 5'($urandom_range(31));
                pipe_wdata = {$urandom, $urandom};
            end
            if (!(mdu_valid && !last_mdu_ready)) begin
                mdu_valid = ($urandom_range(99) < 35);
                mdu_waddr = 5'($urandom_range(31));
                mdu_wdata = {$urandom, $urandom};
            end
            issue_valid = ($urandom_range(99) < 25);
            issue_rd    = 5'($urandom_range(31));
            chk_rs1     = 5'($urandom_range(31));
            chk_rs2     = 5'($urandom_range(31));
            chk_rd      = 5'($urandom_range(31));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
